branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit_if.sv | 61 ++++++
 rtl/branch_resolve_unit.sv | 191 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Bus bundle between the pipeline front end and the branch resolve unit.
// The master side drives the fetch, decode and execute observations.
// The slave side (the resolve unit) returns the predictor update bus,
// the fetch redirect and squash controls, and the performance counters.
`timescale 1ns/1ps
interface branch_resolve_unit_if #(
    parameter int WORD_SIZE = 16
);
    // Fetch stage observation
    logic [WORD_SIZE-1:0] if_pc;
    logic [WORD_SIZE-1:0] if_pred_next;
    logic                 if_valid;
    // Hazard stall for IF/ID
    logic                 stall_id;
    // Decode stage jump
    logic                 id_is_jump;
    logic [WORD_SIZE-1:0] id_jump_target;
    // Execute stage branch
    logic                 ex_is_branch;
    logic                 ex_branch_cond;
    logic [WORD_SIZE-1:0] ex_branch_target;

    // Predictor update bus
    logic                 JumpResolved;
    logic                 BranchResolved;
    logic                 BranchTaken;
    logic [WORD_SIZE-1:0] ResolvedJumpPC;
    logic [WORD_SIZE-1:0] ResolvedBranchPC;
    logic [WORD_SIZE-1:0] ActualJumpTarget;
    logic [WORD_SIZE-1:0] ActualBranchTarget;
    // Fetch correction and squash
    logic                 redirect;
    logic [WORD_SIZE-1:0] redirect_pc;
    logic                 flush_if;
    logic                 flush_id;
    // Performance counters
    logic [15:0]          branch_count;
    logic [15:0]          mispredict_count;

    modport master (
        output if_pc, if_pred_next, if_valid, stall_id,
               id_is_jump, id_jump_target,
               ex_is_branch, ex_branch_cond, ex_branch_target,
        input  JumpResolved, BranchResolved, BranchTaken,
               ResolvedJumpPC, ResolvedBranchPC,
               ActualJumpTarget, ActualBranchTarget,
               redirect, redirect_pc, flush_if, flush_id,
               branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, if_pred_next, if_valid, stall_id,
               id_is_jump, id_jump_target,
               ex_is_branch, ex_branch_cond, ex_branch_target,
        output JumpResolved, BranchResolved, BranchTaken,
               ResolvedJumpPC, ResolvedBranchPC,
               ActualJumpTarget, ActualBranchTarget,
               redirect, redirect_pc, flush_if, flush_id,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit.
// Tracks the instruction sitting in ID and in EX together with the next-PC
// the predictor guessed for it. An EX branch or an ID jump is checked
// against that guess; a wrong guess redirects fetch and squashes younger
// stages, and the outcome is published on the predictor update bus.
// EX-stage corrections always win over ID-stage ones because the EX
// instruction is older. Resolution outputs are combinational so fetch can
// be corrected in the same cycle; only the tracking entries and counters
// are state.
`timescale 1ns/1ps
module branch_resolve_unit #(
    parameter int WORD_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    branch_resolve_unit_if.slave  bus
);

    localparam logic [WORD_SIZE-1:0] PC_STEP  = {{(WORD_SIZE-1){1'b0}}, 1'b1};
    localparam logic [WORD_SIZE-1:0] PC_ZERO  = {WORD_SIZE{1'b0}};
    localparam logic [15:0]          CNT_MAX  = 16'hFFFF;
    localparam logic [15:0]          CNT_STEP = 16'd1;

    // Saturating counter increment: holds at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_STEP;
        end
        return result;
    endfunction

    // Tracking entries (ID and EX) and performance counters
    logic                 id_valid_q, id_valid_d;
    logic [WORD_SIZE-1:0] id_pc_q,    id_pc_d;
    logic [WORD_SIZE-1:0] id_pred_q,  id_pred_d;
    logic                 ex_valid_q, ex_valid_d;
    logic [WORD_SIZE-1:0] ex_pc_q,    ex_pc_d;
    logic [WORD_SIZE-1:0] ex_pred_q,  ex_pred_d;
    logic [15:0]          branch_count_q,     branch_count_d;
    logic [15:0]          mispredict_count_q, mispredict_count_d;

    // Combinational resolution results
    logic [WORD_SIZE-1:0] ex_actual_s;
    logic                 branch_resolved_s;
    logic                 ex_mispredict_s;
    logic                 jump_resolved_s;
    logic                 id_mispredict_s;
    logic                 redirect_s;
    logic [WORD_SIZE-1:0] redirect_pc_s;
    logic                 flush_if_s;
    logic                 flush_id_s;

    // Resolve the EX branch and the ID jump against their predicted next-PC.
    always_comb begin
        ex_actual_s       = PC_ZERO;
        branch_resolved_s = 1'b0;
        ex_mispredict_s   = 1'b0;
        jump_resolved_s   = 1'b0;
        id_mispredict_s   = 1'b0;

        if (bus.ex_branch_cond) begin
            ex_actual_s = bus.ex_branch_target;
        end else begin
            ex_actual_s = ex_pc_q + PC_STEP;
        end

        // Only a valid entry may resolve, so each instruction resolves once.
        branch_resolved_s = ex_valid_q & bus.ex_is_branch;
        ex_mispredict_s   = branch_resolved_s & (ex_actual_s != ex_pred_q);

        // A jump is not resolved while stalled or while an older branch
        // is squashing it.
        jump_resolved_s = id_valid_q & bus.id_is_jump & ~bus.stall_id & ~ex_mispredict_s;
        id_mispredict_s = jump_resolved_s & (bus.id_jump_target != id_pred_q);
    end

    // Choose the fetch correction; the older EX instruction takes priority.
    always_comb begin
        redirect_s    = 1'b0;
        redirect_pc_s = PC_ZERO;
        flush_if_s    = 1'b0;
        flush_id_s    = 1'b0;

        if (ex_mispredict_s) begin
            redirect_s    = 1'b1;
            redirect_pc_s = ex_actual_s;
            flush_if_s    = 1'b1;
            flush_id_s    = 1'b1;
        end else if (id_mispredict_s) begin
            redirect_s    = 1'b1;
            redirect_pc_s = bus.id_jump_target;
            flush_if_s    = 1'b1;
            flush_id_s    = 1'b0;
        end else begin
            redirect_s    = 1'b0;
            redirect_pc_s = PC_ZERO;
            flush_if_s    = 1'b0;
            flush_id_s    = 1'b0;
        end
    end

    // Advance the ID/EX tracking entries; a stall holds ID and bubbles EX.
    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_pred_d  = id_pred_q;
        ex_valid_d = 1'b0;
        ex_pc_d    = ex_pc_q;
        ex_pred_d  = ex_pred_q;

        if (bus.stall_id) begin
            // ID keeps its instruction unless an older branch squashes it.
            id_valid_d = id_valid_q & ~flush_id_s;
            id_pc_d    = id_pc_q;
            id_pred_d  = id_pred_q;
            ex_valid_d = 1'b0;
            ex_pc_d    = id_pc_q;
            ex_pred_d  = id_pred_q;
        end else begin
            id_valid_d = bus.if_valid & ~flush_if_s;
            id_pc_d    = bus.if_pc;
            id_pred_d  = bus.if_pred_next;
            ex_valid_d = id_valid_q & ~flush_id_s;
            ex_pc_d    = id_pc_q;
            ex_pred_d  = id_pred_q;
        end
    end

    // Count resolved branches and mispredicts (at most one per cycle).
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        if (branch_resolved_s) begin
            branch_count_d = sat_inc(branch_count_q);
        end else begin
            branch_count_d = branch_count_q;
        end

        if (ex_mispredict_s | id_mispredict_s) begin
            mispredict_count_d = sat_inc(mispredict_count_q);
        end else begin
            mispredict_count_d = mispredict_count_q;
        end
    end

    // State register for tracking entries and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_valid_q         <= 1'b0;
            id_pc_q            <= PC_ZERO;
            id_pred_q          <= PC_ZERO;
            ex_valid_q         <= 1'b0;
            ex_pc_q            <= PC_ZERO;
            ex_pred_q          <= PC_ZERO;
            branch_count_q     <= 16'd0;
            mispredict_count_q <= 16'd0;
        end else begin
            id_valid_q         <= id_valid_d;
            id_pc_q            <= id_pc_d;
            id_pred_q          <= id_pred_d;
            ex_valid_q         <= ex_valid_d;
            ex_pc_q            <= ex_pc_d;
            ex_pred_q          <= ex_pred_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Drive the update bus; data fields read zero unless their strobe is set,
    // so nothing leaks from the raw inputs while entries are invalid.
    always_comb begin
        bus.BranchResolved     = branch_resolved_s;
        bus.BranchTaken        = branch_resolved_s & bus.ex_branch_cond;
        bus.ResolvedBranchPC   = branch_resolved_s ? ex_pc_q : PC_ZERO;
        bus.ActualBranchTarget = branch_resolved_s ? bus.ex_branch_target : PC_ZERO;
        bus.JumpResolved       = jump_resolved_s;
        bus.ResolvedJumpPC     = jump_resolved_s ? id_pc_q : PC_ZERO;
        bus.ActualJumpTarget   = jump_resolved_s ? bus.id_jump_target : PC_ZERO;
        bus.redirect           = redirect_s;
        bus.redirect_pc        = redirect_pc_s;
        bus.flush_if           = flush_if_s;
        bus.flush_id           = flush_id_s;
        bus.branch_count       = branch_count_q;
        bus.mispredict_count   = mispredict_count_q;
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit. Each cycle's expected
// outputs are queued while the stimulus is driven and drained against the
// DUT at the following falling edge.
`timescale 1ns/1ps
module tb_branch_resolve_unit;

    localparam int W = 16;

    localparam int S_JR   = 0;
    localparam int S_BR   = 1;
    localparam int S_BT   = 2;
    localparam int S_RJPC = 3;
    localparam int S_RBPC = 4;
    localparam int S_AJT  = 5;
    localparam int S_ABT  = 6;
    localparam int S_RED  = 7;
    localparam int S_RPC  = 8;
    localparam int S_FIF  = 9;
    localparam int S_FID  = 10;
    localparam int S_BCNT = 11;
    localparam int S_MCNT = 12;

    logic clk;
    logic reset_n;

    branch_resolve_unit_if #(.WORD_SIZE(W)) bus ();

    branch_resolve_unit #(.WORD_SIZE(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run;
    int   tests_failed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when it disagrees.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] actual(input int sel);
        logic [31:0] v;
        case (sel)
            S_JR:    v = 32'(bus.JumpResolved);
            S_BR:    v = 32'(bus.BranchResolved);
            S_BT:    v = 32'(bus.BranchTaken);
            S_RJPC:  v = 32'(bus.ResolvedJumpPC);
            S_RBPC:  v = 32'(bus.ResolvedBranchPC);
            S_AJT:   v = 32'(bus.ActualJumpTarget);
            S_ABT:   v = 32'(bus.ActualBranchTarget);
            S_RED:   v = 32'(bus.redirect);
            S_RPC:   v = 32'(bus.redirect_pc);
            S_FIF:   v = 32'(bus.flush_if);
            S_FID:   v = 32'(bus.flush_id);
            S_BCNT:  v = 32'(bus.branch_count);
            S_MCNT:  v = 32'(bus.mispredict_count);
            default: v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, actual(e.sel), e.val);
        end
    endtask

    // Compare at the falling edge, then move past the next rising edge.
    task automatic step();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_pc            = 16'h0000;
        bus.if_pred_next     = 16'h0000;
        bus.if_valid         = 1'b0;
        bus.stall_id         = 1'b0;
        bus.id_is_jump       = 1'b0;
        bus.id_jump_target   = 16'h0000;
        bus.ex_is_branch     = 1'b0;
        bus.ex_branch_cond   = 1'b0;
        bus.ex_branch_target = 16'h0000;
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [15:0] pred);
        bus.if_valid     = 1'b1;
        bus.if_pc        = pc;
        bus.if_pred_next = pred;
    endtask

    task automatic expect_all_zero(input string tag);
        for (int s = 0; s <= S_MCNT; s++) begin
            expect_out($sformatf("%s_o%0d", tag, s), s, 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset with busy-looking inputs: everything must read zero.
        reset_n = 1'b0;
        idle();
        fetch(16'h1111, 16'h2222);
        bus.id_is_jump       = 1'b1;
        bus.id_jump_target   = 16'h3333;
        bus.ex_is_branch     = 1'b1;
        bus.ex_branch_cond   = 1'b1;
        bus.ex_branch_target = 16'h1234;
        @(posedge clk);
        #1;
        expect_all_zero("rst");
        step();
        reset_n = 1'b1;
        idle();

        // Correct prediction: taken branch to the predicted target.
        fetch(16'h0010, 16'h0020); step();
        idle();
        expect_out("cp_id_jr", S_JR, 32'd0);
        expect_out("cp_id_br", S_BR, 32'd0);
        step();
        bus.ex_is_branch = 1'b1; bus.ex_branch_cond = 1'b1; bus.ex_branch_target = 16'h0020;
        expect_out("cp_br",   S_BR,   32'd1);
        expect_out("cp_bt",   S_BT,   32'd1);
        expect_out("cp_rbpc", S_RBPC, 32'h0010);
        expect_out("cp_abt",  S_ABT,  32'h0020);
        expect_out("cp_red",  S_RED,  32'd0);
        expect_out("cp_fif",  S_FIF,  32'd0);
        expect_out("cp_fid",  S_FID,  32'd0);
        expect_out("cp_rpc",  S_RPC,  32'd0);
        step();
        idle();
        expect_out("cp_bcnt", S_BCNT, 32'd1);
        expect_out("cp_mcnt", S_MCNT, 32'd0);
        step();

        // Branch mispredict: predicted taken, actually falls through.
        fetch(16'h0010, 16'h0020); step();
        fetch(16'h0011, 16'h0012); step();
        fetch(16'h0012, 16'h0013);
        bus.ex_is_branch = 1'b1; bus.ex_branch_cond = 1'b0; bus.ex_branch_target = 16'h0020;
        expect_out("bm_br",  S_BR,  32'd1);
        expect_out("bm_bt",  S_BT,  32'd0);
        expect_out("bm_jr",  S_JR,  32'd0);
        expect_out("bm_red", S_RED, 32'd1);
        expect_out("bm_rpc", S_RPC, 32'h0011);
        expect_out("bm_fif", S_FIF, 32'd1);
        expect_out("bm_fid", S_FID, 32'd1);
        step();
        idle();
        bus.ex_is_branch = 1'b1; bus.ex_branch_cond = 1'b0; bus.ex_branch_target = 16'h0020;
        bus.id_is_jump = 1'b1; bus.id_jump_target = 16'h0055;
        expect_out("bm_post_br",  S_BR,   32'd0);
        expect_out("bm_post_jr",  S_JR,   32'd0);
        expect_out("bm_post_red", S_RED,  32'd0);
        expect_out("bm_bcnt",     S_BCNT, 32'd2);
        expect_out("bm_mcnt",     S_MCNT, 32'd1);
        step();
        idle();

        // Jump mispredict in ID with no branch in EX.
        fetch(16'h0030, 16'h0031); step();
        fetch(16'h0031, 16'h0032);
        bus.id_is_jump = 1'b1; bus.id_jump_target = 16'h0100;
        expect_out("jm_jr",   S_JR,   32'd1);
        expect_out("jm_rjpc", S_RJPC, 32'h0030);
        expect_out("jm_ajt",  S_AJT,  32'h0100);
        expect_out("jm_red",  S_RED,  32'd1);
        expect_out("jm_rpc",  S_RPC,  32'h0100);
        expect_out("jm_fif",  S_FIF,  32'd1);
        expect_out("jm_fid",  S_FID,  32'd0);
        expect_out("jm_br",   S_BR,   32'd0);
        step();
        idle();
        bus.id_is_jump = 1'b1; bus.id_jump_target = 16'h0100;
        expect_out("jm_post_jr",  S_JR,   32'd0);
        expect_out("jm_post_red", S_RED,  32'd0);
        expect_out("jm_mcnt",     S_MCNT, 32'd2);
        step();
        idle();

        // Correctly predicted jump: resolves without redirect.
        fetch(16'h0040, 16'h0050); step();
        idle();
        bus.id_is_jump = 1'b1; bus.id_jump_target = 16'h0050;
        expect_out("jc_jr",  S_JR,  32'd1);
        expect_out("jc_red", S_RED, 32'd0);
        expect_out("jc_rpc", S_RPC, 32'd0);
        step();
        idle();
        expect_out("jc_mcnt", S_MCNT, 32'd2);
        step();

        // EX branch mispredict and ID jump mispredict in the same cycle.
        fetch(16'h0060, 16'h0061); step();
        fetch(16'h0061, 16'h0062); step();
        idle();
        bus.ex_is_branch = 1'b1; bus.ex_branch_cond = 1'b1; bus.ex_branch_target = 16'h0080;
        bus.id_is_jump = 1'b1; bus.id_jump_target = 16'h0200;
        expect_out("sim_jr",  S_JR,  32'd0);
        expect_out("sim_br",  S_BR,  32'd1);
        expect_out("sim_red", S_RED, 32'd1);
        expect_out("sim_rpc", S_RPC, 32'h0080);
        expect_out("sim_fif", S_FIF, 32'd1);
        expect_out("sim_fid", S_FID, 32'd1);
        step();
        idle();
        expect_out("sim_mcnt", S_MCNT, 32'd3);
        expect_out("sim_bcnt", S_BCNT, 32'd3);
        step();

        // Stall holds the jump in ID and bubbles EX.
        fetch(16'h0070, 16'h0071); step();
        fetch(16'h0099, 16'h009A);
        bus.stall_id = 1'b1;
        bus.id_is_jump = 1'b1; bus.id_jump_target = 16'h0300;
        expect_out("st_jr",  S_JR,  32'd0);
        expect_out("st_red", S_RED, 32'd0);
        step();
        idle();
        bus.id_is_jump = 1'b1; bus.id_jump_target = 16'h0300;
        bus.ex_is_branch = 1'b1; bus.ex_branch_cond = 1'b0;
        expect_out("st_jr2",  S_JR,   32'd1);
        expect_out("st_rjpc", S_RJPC, 32'h0070);
        expect_out("st_rpc",  S_RPC,  32'h0300);
        expect_out("st_br",   S_BR,   32'd0);
        step();
        idle();
        expect_out("st_mcnt", S_MCNT, 32'd4);
        expect_out("st_bcnt", S_BCNT, 32'd3);
        step();
        step();

        // Fall-through from the top address wraps to zero.
        fetch(16'hFFFF, 16'h0000); step();
        idle(); step();
        bus.ex_is_branch = 1'b1; bus.ex_branch_cond = 1'b0; bus.ex_branch_target = 16'h1234;
        expect_out("wr_br",   S_BR,   32'd1);
        expect_out("wr_red",  S_RED,  32'd0);
        expect_out("wr_rbpc", S_RBPC, 32'hFFFF);
        step();
        idle();
        expect_out("wr_bcnt", S_BCNT, 32'd4);
        expect_out("wr_mcnt", S_MCNT, 32'd4);
        step();

        // Clear counters, then drive 65535 mispredicts and one more.
        reset_n = 1'b0;
        #1;
        expect_out("sat_rst_m", S_MCNT, 32'd0);
        expect_out("sat_rst_b", S_BCNT, 32'd0);
        drain();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        fetch(16'h0500, 16'h0501); step();
        for (int k = 0; k < 32767; k++) begin
            idle();
            bus.id_is_jump = 1'b1; bus.id_jump_target = 16'h0600;
            step();
            idle();
            bus.ex_is_branch = 1'b1; bus.ex_branch_cond = 1'b1; bus.ex_branch_target = 16'h0700;
            step();
            idle();
            fetch(16'h0500, 16'h0501);
            step();
        end
        idle();
        bus.id_is_jump = 1'b1; bus.id_jump_target = 16'h0600;
        expect_out("sat_pre", S_MCNT, 32'd65534);
        step();
        idle();
        bus.ex_is_branch = 1'b1; bus.ex_branch_cond = 1'b1; bus.ex_branch_target = 16'h0700;
        expect_out("sat_full", S_MCNT, 32'hFFFF);
        expect_out("sat_red",  S_RED,  32'd1);
        step();
        idle();
        expect_out("sat_hold", S_MCNT, 32'hFFFF);
        expect_out("sat_bcnt", S_BCNT, 32'd32768);
        step();

        // Asynchronous reset in the middle of a pending squash.
        fetch(16'h0010, 16'h0020); step();
        idle(); step();
        bus.ex_is_branch = 1'b1; bus.ex_branch_cond = 1'b0; bus.ex_branch_target = 16'h0020;
        #1;
        expect_out("ar_red", S_RED, 32'd1);
        expect_out("ar_fid", S_FID, 32'd1);
        drain();
        reset_n = 1'b0;
        #1;
        expect_all_zero("ar");
        drain();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        expect_out("ar_rel_red", S_RED, 32'd0);
        expect_out("ar_rel_br",  S_BR,  32'd0);
        expect_out("ar_rel_fif", S_FIF, 32'd0);
        expect_out("ar_rel_m",   S_MCNT, 32'd0);
        drain();
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
